// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment driver: one digit per rising edge of the divided scan wave,
// with BCD decode, leading-zero blanking and selectable output polarities.
module bcd_display_scan #(
  parameter int NDIG           = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              scan_clk,
  input  logic [4*NDIG-1:0] bcd,
  input  logic [NDIG-1:0]   dp_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an
);

  localparam int   IW      = $clog2(NDIG);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic            s1_q, s2_q, s3_q;
  logic            tick;
  logic [IW-1:0]   idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [NDIG-1:0] an_q, an_d;

  logic [3:0]      digit;
  logic            dp_sel;
  logic            blank;
  logic            run_zero;
  logic [NDIG-1:0] an_hi;
  logic [6:0]      seg_hi;

  // scan_clk is asynchronous to clkin; s1/s2 synchronise, s3 provides the edge history.
  assign tick = s2_q & ~s3_q;

  always_comb begin
    idx_d    = (idx_q == IW'(NDIG-1)) ? '0 : idx_q + 1'b1;
    digit    = '0;
    dp_sel   = 1'b0;
    blank    = 1'b0;
    run_zero = 1'b1;
    an_hi    = '0;
    // Walk from MSD down; run_zero stays set while every digit so far is zero.
    for (int i = NDIG-1; i >= 0; i--) begin
      run_zero = run_zero & (bcd[4*i +: 4] == 4'd0);
      if (idx_d == IW'(i)) begin
        digit    = bcd[4*i +: 4];
        dp_sel   = dp_mask[i];
        blank    = (BLANK_LEADING != 0) && (i > 0) && run_zero;
        an_hi[i] = 1'b1;
      end
    end

    case (digit)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      default: seg_hi = 7'h40;
    endcase

    seg_d = (blank ? 7'h00 : seg_hi) ^ {7{SEG_INV}};
    dp_d  = (blank ? 1'b0 : dp_sel) ^ SEG_INV;
    an_d  = (blank ? '0 : an_hi) ^ {NDIG{AN_INV}};
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      idx_q <= IW'(NDIG-1);
      seg_q <= {7{SEG_INV}};
      dp_q  <= SEG_INV;
      an_q  <= {NDIG{AN_INV}};
    end else begin
      s1_q <= scan_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (tick) begin
        idx_q <= idx_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
        an_q  <= an_d;
      end
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: default instance plus a no-blanking instance,
// expected {seg,dp,an} queued at each scan_clk rise and compared when the update lands.
module tb_bcd_display_scan;

  localparam int NDIG = 4;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [3:0]  an, an_nb;

  int checks = 0;
  int failures = 0;
  int idx_m = NDIG-1;
  logic [23:0] sb_q[$];
  logic [11:0] last_main;
  logic [6:0]  seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_display_scan #(.NDIG(NDIG)) dut (
    .clkin(clkin), .rst_n(rst_n), .scan_clk(scan_clk), .bcd(bcd),
    .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an));

  bcd_display_scan #(.NDIG(NDIG), .BLANK_LEADING(0)) dut_nb (
    .clkin(clkin), .rst_n(rst_n), .scan_clk(scan_clk), .bcd(bcd),
    .dp_mask(dp_mask), .seg(seg_nb), .dp(dp_nb), .an(an_nb));

  always #5 clkin = ~clkin;

  function automatic logic [11:0] model(logic [15:0] b, logic [3:0] m, int idx, bit blank_en);
    logic [3:0] d;
    logic [6:0] hi;
    bit blanked;
    d = b[idx*4 +: 4];
    blanked = 1'b0;
    if (blank_en && idx > 0) begin
      blanked = 1'b1;
      for (int j = idx; j < NDIG; j++)
        if (b[j*4 +: 4] != 4'd0) blanked = 1'b0;
    end
    hi = (d <= 4'd9) ? seg_tbl[d] : 7'h40;
    if (blanked) return {7'h7F, 1'b1, 4'hF};
    return {~hi, ~m[idx], ~(4'b0001 << idx)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One scan step: rise at a negedge, check no early update at E1, pop at E2,
  // then hold high and require the anodes to stay put.
  task automatic scan_step(string tag, int hold);
    logic [23:0] exp;
    logic [3:0]  an_prev;
    int          changes;
    @(negedge clkin);
    scan_clk = 1'b1;
    idx_m = (idx_m == NDIG-1) ? 0 : idx_m + 1;
    sb_q.push_back({model(bcd, dp_mask, idx_m, 1'b1), model(bcd, dp_mask, idx_m, 1'b0)});
    @(posedge clkin);
    @(posedge clkin); #1;
    check({tag, "_early"}, {seg, dp, an}, last_main);
    @(posedge clkin); #1;
    exp = sb_q.pop_front();
    check({tag, "_main"}, {seg, dp, an}, exp[23:12]);
    check({tag, "_noblank"}, {seg_nb, dp_nb, an_nb}, exp[11:0]);
    last_main = exp[23:12];
    an_prev = an;
    changes = 0;
    repeat (hold) begin
      @(posedge clkin); #1;
      if (an !== an_prev) changes++;
      an_prev = an;
    end
    check({tag, "_hold"}, changes, 0);
    @(negedge clkin);
    scan_clk = 1'b0;
    repeat (3) @(posedge clkin);
  endtask

  initial begin
    last_main = {7'h7F, 1'b1, 4'hF};

    // Reset held with scan_clk toggling: outputs stay dark.
    for (int i = 0; i < 3; i++) begin
      @(negedge clkin);
      scan_clk = ~scan_clk;
      @(posedge clkin); #1;
      check("reset_dark", {seg, dp, an}, {7'h7F, 1'b1, 4'hF});
    end
    @(negedge clkin);
    scan_clk = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clkin);
    #1 check("post_release_dark", {seg, dp, an}, {7'h7F, 1'b1, 4'hF});

    // Scan order with a decimal point on digit 2; first step also holds 100 cycles.
    bcd = 16'h1234;
    dp_mask = 4'b0100;
    scan_step("d0_1234", 100);
    check("d0_an", an, 4'hE);
    check("d0_seg", seg, 7'h19);
    scan_step("d1_1234", 5);
    check("d1_seg", seg, 7'h30);
    scan_step("d2_1234", 5);
    check("d2_dp", {dp, an}, {1'b0, 4'hB});
    scan_step("d3_1234", 5);
    check("d3_seg", {seg, dp, an}, {7'h79, 1'b1, 4'h7});

    // Leading-zero blanking.
    bcd = 16'h0007;
    dp_mask = 4'b1111;
    for (int i = 0; i < 4; i++) scan_step("blank_0007", 3);
    check("blank_d3_dark", {seg, dp, an}, {7'h7F, 1'b1, 4'hF});

    // Invalid code shows a dash and counts as nonzero.
    bcd = 16'h0A05;
    dp_mask = 4'b0000;
    scan_step("inv_d0", 3);
    check("inv_d0_seg", seg, 7'h12);
    scan_step("inv_d1", 3);
    check("inv_d1_seg", seg, 7'h40);
    scan_step("inv_d2", 3);
    check("inv_d2_seg", seg, 7'h3F);
    scan_step("inv_d3", 3);

    // Inputs changing between ticks must not disturb the held outputs.
    bcd = 16'h9876;
    dp_mask = 4'b0011;
    scan_step("mid_d0", 3);
    bcd = 16'h0000;
    dp_mask = 4'b1111;
    repeat (6) @(posedge clkin);
    #1 check("mid_hold", {seg, dp, an}, last_main);
    bcd = 16'h9876;
    dp_mask = 4'b0011;
    scan_step("mid_d1", 3);
    scan_step("mid_d2", 3);

    // Reset at idx=2, with a scan rise in flight so its tick lands inside reset.
    @(negedge clkin);
    scan_clk = 1'b1;
    rst_n = 1'b0;
    @(posedge clkin); #1;
    check("rst_mid_dark", {seg, dp, an}, {7'h7F, 1'b1, 4'hF});
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    scan_clk = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clkin);
    #1 check("rst_mid_still_dark", {seg, dp, an}, {7'h7F, 1'b1, 4'hF});
    idx_m = NDIG-1;
    last_main = {7'h7F, 1'b1, 4'hF};
    scan_step("after_rst", 3);
    check("after_rst_an", an, 4'hE);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
